// File: rtl/pic_core.sv
// rtl/pic_core.sv - 32-source priority interrupt controller with memory-mapped management port
// Define PIC_EDGE_EN for rising-edge capture of irq; default build captures level.
module pic_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] irq,
    output logic        exi,
    output logic [4:0]  exi_code,
    input  logic        mgmt_req,
    input  logic [31:0] mgmt_adr,
    input  logic        mgmt_rwn,
    input  logic [1:0]  mgmt_wen,
    input  logic [31:0] mgmt_txd,
    output logic        mgmt_ack,
    output logic        mgmt_rxe,
    output logic [31:0] mgmt_rxd
);

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_CLAIM   = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    logic [31:0] pending_q, pending_d;
    logic [31:0] enable_q, enable_d;
    logic        ack_q, ack_d;
    logic        rxe_q, rxe_d;
    logic [31:0] rxd_q, rxd_d;

    logic [31:0] active;
    logic [31:0] lane_mask;
    logic [31:0] set_bits;
    logic [31:0] clr_bits;
    logic [31:0] rd_data;
    logic [1:0]  offset;
    logic        in_win;
    logic        accept;
    logic        rd_acc;
    logic        wr_acc;
    logic        unused_adr_bits;

    assign unused_adr_bits = ^mgmt_adr[1:0];

`ifdef PIC_EDGE_EN
    logic [31:0] irq_prev_q, irq_prev_d;

    always_comb begin
        irq_prev_d = irq;
        set_bits   = irq & ~irq_prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) irq_prev_q <= '0;
        else     irq_prev_q <= irq_prev_d;
    end
`else
    always_comb begin
        set_bits = irq;
    end
`endif

    // Lowest active index wins: scan downward so bit 0 overrides.
    always_comb begin
        active   = pending_q & enable_q;
        exi      = |active;
        exi_code = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (active[i]) exi_code = 5'(i);
        end
    end

    always_comb begin
        in_win    = (mgmt_adr[31:4] == 28'hFFFF_F02);
        offset    = mgmt_adr[3:2];
        accept    = mgmt_req & in_win & ~ack_q;
        rd_acc    = accept & mgmt_rwn;
        wr_acc    = accept & ~mgmt_rwn;
        lane_mask = {{16{mgmt_wen[1]}}, {16{mgmt_wen[0]}}};

        case (offset)
            REG_PENDING: rd_data = pending_q;
            REG_ENABLE:  rd_data = enable_q;
            REG_CLAIM:   rd_data = {exi, 26'b0, exi_code};
            REG_STATUS:  rd_data = active;
            default:     rd_data = '0;
        endcase

        clr_bits = '0;
        if (wr_acc && offset == REG_PENDING) clr_bits = mgmt_txd & lane_mask;
        if (rd_acc && offset == REG_CLAIM && exi) clr_bits = 32'd1 << exi_code;

        // Clear first, then OR in new captures so a simultaneous set survives.
        pending_d = (pending_q & ~clr_bits) | set_bits;

        enable_d = enable_q;
        if (wr_acc && offset == REG_ENABLE)
            enable_d = (enable_q & ~lane_mask) | (mgmt_txd & lane_mask);

        ack_d = accept;
        rxe_d = rd_acc;
        rxd_d = rd_acc ? rd_data : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            enable_q  <= '0;
            ack_q     <= 1'b0;
            rxe_q     <= 1'b0;
            rxd_q     <= '0;
        end else begin
            pending_q <= pending_d;
            enable_q  <= enable_d;
            ack_q     <= ack_d;
            rxe_q     <= rxe_d;
            rxd_q     <= rxd_d;
        end
    end

    assign mgmt_ack = ack_q;
    assign mgmt_rxe = rxe_q;
    assign mgmt_rxd = rxd_q;

endmodule

// File: tb/tb_pic_core.sv
// tb/tb_pic_core.sv - self-checking bench for pic_core against a behavioural model
module tb_pic_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] irq;
    logic        exi;
    logic [4:0]  exi_code;
    logic        mgmt_req;
    logic [31:0] mgmt_adr;
    logic        mgmt_rwn;
    logic [1:0]  mgmt_wen;
    logic [31:0] mgmt_txd;
    logic        mgmt_ack;
    logic        mgmt_rxe;
    logic [31:0] mgmt_rxd;

    int checks = 0;
    int passed = 0;

    localparam logic [31:0] A_PEND  = 32'hFFFF_F020;
    localparam logic [31:0] A_EN    = 32'hFFFF_F024;
    localparam logic [31:0] A_CLAIM = 32'hFFFF_F028;
    localparam logic [31:0] A_STAT  = 32'hFFFF_F02C;

    // Reference model state: pending/enable sets, previous irq, bus reply.
    logic [31:0] m_pend, m_en, m_prev, m_rxd;
    logic        m_ack, m_rxe;

    pic_core dut (
        .clk(clk), .rst(rst), .irq(irq), .exi(exi), .exi_code(exi_code),
        .mgmt_req(mgmt_req), .mgmt_adr(mgmt_adr), .mgmt_rwn(mgmt_rwn),
        .mgmt_wen(mgmt_wen), .mgmt_txd(mgmt_txd), .mgmt_ack(mgmt_ack),
        .mgmt_rxe(mgmt_rxe), .mgmt_rxd(mgmt_rxd)
    );

    always #5 clk = ~clk;

    function automatic logic m_exi();
        return (m_pend & m_en) != 32'd0;
    endfunction

    function automatic logic [4:0] m_code();
        logic [31:0] act;
        act = m_pend & m_en;
        for (int i = 0; i < 32; i++) if (act[i]) return 5'(i);
        return 5'd0;
    endfunction

    // Advance one clock, updating the model from the inputs currently driven.
    task automatic tick();
        logic [31:0] nxt_pend, nxt_en, word, lanes;
        logic        acc;
        nxt_pend = m_pend;
        nxt_en   = m_en;
        if (rst) begin
            m_pend = 0; m_en = 0; m_prev = 0; m_ack = 0; m_rxe = 0; m_rxd = 0;
        end else begin
            acc   = mgmt_req && (mgmt_adr >= 32'hFFFF_F020) && (mgmt_adr <= 32'hFFFF_F02F) && !m_ack;
            lanes = (mgmt_wen[0] ? 32'h0000_FFFF : 0) | (mgmt_wen[1] ? 32'hFFFF_0000 : 0);
            case (mgmt_adr[3:2])
                2'd0: word = m_pend;
                2'd1: word = m_en;
                2'd2: word = m_exi() ? (32'h8000_0000 + 32'(m_code())) : 32'd0;
                default: word = m_pend & m_en;
            endcase
            if (acc && !mgmt_rwn && mgmt_adr[3:2] == 2'd0) nxt_pend = nxt_pend & ~(mgmt_txd & lanes);
            if (acc && !mgmt_rwn && mgmt_adr[3:2] == 2'd1) nxt_en = (m_en & ~lanes) | (mgmt_txd & lanes);
            if (acc && mgmt_rwn && mgmt_adr[3:2] == 2'd2 && m_exi()) nxt_pend[m_code()] = 1'b0;
`ifdef PIC_EDGE_EN
            nxt_pend = nxt_pend | (irq & ~m_prev);
`else
            nxt_pend = nxt_pend | irq;
`endif
            m_prev = irq;
            m_pend = nxt_pend;
            m_en   = nxt_en;
            m_ack  = acc;
            m_rxe  = acc && mgmt_rwn;
            m_rxd  = (acc && mgmt_rwn) ? word : 32'd0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] adr, output logic [31:0] data, output logic ok);
        ok = 1'b0; data = 0;
        mgmt_req = 1; mgmt_rwn = 1; mgmt_adr = adr; mgmt_wen = 2'b11;
        for (int k = 0; k < 4 && !ok; k++) begin
            tick();
            if (mgmt_ack) begin ok = 1'b1; data = mgmt_rxd; mgmt_req = 0; end
        end
        mgmt_req = 0;
        tick();
    endtask

    task automatic do_write(input logic [31:0] adr, input logic [31:0] d, input logic [1:0] wen, output logic ok);
        ok = 1'b0;
        mgmt_req = 1; mgmt_rwn = 0; mgmt_adr = adr; mgmt_txd = d; mgmt_wen = wen;
        for (int k = 0; k < 4 && !ok; k++) begin
            tick();
            if (mgmt_ack) begin ok = 1'b1; mgmt_req = 0; end
        end
        mgmt_req = 0;
        tick();
    endtask

    task automatic pulse_irq(input logic [31:0] bits);
        irq = bits; tick(); irq = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic ok;
        rst = 1; tick(); tick(); rst = 0;
        checks++; if (exi !== 1'b0) $display("FAIL reset_exi got %0b want 0", exi); else passed++;
        checks++; if (exi_code !== 5'd0) $display("FAIL reset_code got %0d want 0", exi_code); else passed++;
        checks++; if ({mgmt_ack, mgmt_rxe} !== 2'b00) $display("FAIL reset_ack_rxe got %b want 00", {mgmt_ack, mgmt_rxe}); else passed++;
        checks++; if (mgmt_rxd !== 32'd0) $display("FAIL reset_rxd got %h want 0", mgmt_rxd); else passed++;
        do_read(A_EN, d, ok);
        checks++; if (!ok || d !== 32'd0) $display("FAIL reset_enable got %h ok %0b want 0", d, ok); else passed++;
    endtask

    task automatic test_basic();
        logic [31:0] d; logic ok;
        do_write(A_EN, 32'h0000_0009, 2'b11, ok);
        pulse_irq(32'h0000_0008);
        checks++; if (exi !== 1'b1 || exi_code !== 5'd3) $display("FAIL basic_exi got %0b/%0d want 1/3", exi, exi_code); else passed++;
        do_read(A_PEND, d, ok);
        checks++; if (!ok || d !== 32'h0000_0008) $display("FAIL basic_pending got %h want 00000008", d); else passed++;
    endtask

    task automatic test_claim();
        logic [31:0] d; logic ok;
        do_write(A_PEND, 32'hFFFF_FFFF, 2'b11, ok);
        pulse_irq(32'h0000_0009);
        checks++; if (exi_code !== 5'd0 || exi !== 1'b1) $display("FAIL claim_code got %0b/%0d want 1/0", exi, exi_code); else passed++;
        do_read(A_CLAIM, d, ok);
        checks++; if (!ok || d !== 32'h8000_0000) $display("FAIL claim_first got %h want 80000000", d); else passed++;
        do_read(A_CLAIM, d, ok);
        checks++; if (!ok || d !== 32'h8000_0003) $display("FAIL claim_second got %h want 80000003", d); else passed++;
        do_read(A_CLAIM, d, ok);
        checks++; if (!ok || d !== 32'h0000_0000) $display("FAIL claim_third got %h want 0", d); else passed++;
        checks++; if (exi !== 1'b0) $display("FAIL claim_exi got %0b want 0", exi); else passed++;
    endtask

    task automatic test_lanes();
        logic [31:0] d; logic ok;
        do_write(A_EN, 32'h0000_0000, 2'b11, ok);
        do_write(A_EN, 32'hFFFF_FFFF, 2'b01, ok);
        do_read(A_EN, d, ok);
        checks++; if (!ok || d !== 32'h0000_FFFF) $display("FAIL lanes_enable got %h want 0000ffff", d); else passed++;
        pulse_irq(32'h0000_0008);
        do_write(A_CLAIM, 32'hFFFF_FFFF, 2'b11, ok);
        do_write(A_STAT, 32'hFFFF_FFFF, 2'b11, ok);
        do_read(A_PEND, d, ok);
        checks++; if (!ok || d !== 32'h0000_0008) $display("FAIL ro_write_effect got %h want 00000008", d); else passed++;
        do_write(A_PEND, 32'h0000_0008, 2'b11, ok);
        do_read(A_PEND, d, ok);
        checks++; if (!ok || d !== 32'h0000_0000) $display("FAIL w1c_clear got %h want 0", d); else passed++;
        do_read(A_STAT, d, ok);
        checks++; if (!ok || d !== 32'h0000_0000) $display("FAIL status_empty got %h want 0", d); else passed++;
    endtask

    task automatic test_outside();
        int bad = 0;
        mgmt_req = 1; mgmt_rwn = 1; mgmt_adr = 32'hFFFF_F100;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (mgmt_ack || mgmt_rxe || mgmt_rxd != 0) bad++;
        end
        mgmt_req = 0; tick();
        checks++; if (bad != 0) $display("FAIL outside_window got %0d active cycles want 0", bad); else passed++;
    endtask

    task automatic test_set_wins();
        logic [31:0] d; logic ok;
        irq = 0; tick();
        mgmt_req = 1; mgmt_rwn = 0; mgmt_adr = A_PEND; mgmt_txd = 32'h0000_0020; mgmt_wen = 2'b11;
        irq = 32'h0000_0020;
        tick();
        mgmt_req = 0; irq = 0;
        checks++; if (mgmt_ack !== 1'b1) $display("FAIL set_wins_ack got %0b want 1", mgmt_ack); else passed++;
        tick();
        do_read(A_PEND, d, ok);
        checks++; if (!ok || d[5] !== 1'b1) $display("FAIL set_wins_pending got %h want bit5 set", d); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic ok;
        logic [3:0] pat;
        mgmt_req = 1; mgmt_rwn = 1; mgmt_adr = A_EN;
        for (int k = 0; k < 4; k++) begin
            tick();
            pat[k] = mgmt_ack;
        end
        mgmt_req = 0; tick();
        checks++; if (pat !== 4'b0101) $display("FAIL held_req_acks got %b want 0101", pat); else passed++;
        irq = 32'h0000_0003; tick(); irq = 0;
        mgmt_req = 1; mgmt_rwn = 1; mgmt_adr = A_PEND; rst = 1;
        tick();
        rst = 0; mgmt_req = 0;
        checks++; if (mgmt_ack !== 1'b0 || mgmt_rxe !== 1'b0) $display("FAIL rst_cancel got ack %0b rxe %0b want 0 0", mgmt_ack, mgmt_rxe); else passed++;
        tick();
        checks++; if (mgmt_ack !== 1'b0) $display("FAIL rst_no_late_ack got %0b want 0", mgmt_ack); else passed++;
        do_read(A_PEND, d, ok);
        checks++; if (!ok || d !== 32'd0) $display("FAIL rst_pending got %h want 0", d); else passed++;
        do_read(A_EN, d, ok);
        checks++; if (!ok || d !== 32'd0) $display("FAIL rst_enable got %h want 0", d); else passed++;
    endtask

    task automatic test_random();
        int errs = 0;
        logic [31:0] adrs [5];
        adrs[0] = A_PEND; adrs[1] = A_EN; adrs[2] = A_CLAIM; adrs[3] = A_STAT; adrs[4] = 32'hFFFF_F030;
        for (int k = 0; k < 600; k++) begin
            irq      = $urandom & $urandom & $urandom;
            mgmt_req = ($urandom_range(0, 2) != 0);
            mgmt_adr = adrs[$urandom_range(0, 4)] | 32'($urandom_range(0, 3));
            mgmt_rwn = $urandom_range(0, 1);
            mgmt_wen = 2'($urandom_range(0, 3));
            mgmt_txd = $urandom;
            rst      = ($urandom_range(0, 199) == 0);
            tick();
            if (exi !== m_exi() || exi_code !== m_code() || mgmt_ack !== m_ack ||
                mgmt_rxe !== m_rxe || mgmt_rxd !== m_rxd) begin
                errs++;
                if (errs < 5)
                    $display("FAIL random_cycle%0d got exi %0b code %0d ack %0b rxe %0b rxd %h want %0b %0d %0b %0b %h",
                             k, exi, exi_code, mgmt_ack, mgmt_rxe, mgmt_rxd,
                             m_exi(), m_code(), m_ack, m_rxe, m_rxd);
            end
        end
        rst = 0; mgmt_req = 0; irq = 0; tick();
        checks++; if (errs != 0) $display("FAIL random_total got %0d mismatching cycles want 0", errs); else passed++;
    endtask

    initial begin
        rst = 1; irq = 0; mgmt_req = 0; mgmt_adr = 0; mgmt_rwn = 1; mgmt_wen = 0; mgmt_txd = 0;
        m_pend = 0; m_en = 0; m_prev = 0; m_ack = 0; m_rxe = 0; m_rxd = 0;
        #1;
        test_reset();
        test_basic();
        test_claim();
        test_lanes();
        test_outside();
        test_set_wins();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
